mem_access_stage: RTL and testbench

//  Data-memory access stage between the EX/MEM and MEM/WB pipeline registers. Accepts one

---
 rtl/mem_access_stage.sv | 142 ++++++++++++++
 tb/tb_mem_access_stage.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: data-memory access stage between EX/MEM and MEM/WB.
// Issues loads/stores on a req/ack bus with a timeout and registers one result per instruction.
module mem_access_stage #(
  parameter int TIMEOUT = 16,
  parameter int REG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_mem_read,
  input  logic             in_mem_write,
  input  logic [1:0]       in_wb_ctrl,
  input  logic [31:0]      in_alu_result,
  input  logic [31:0]      in_write_data,
  input  logic [REG_W-1:0] in_write_reg,
  output logic             stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  output logic             out_valid,
  output logic [1:0]       control_signal_WB,
  output logic [31:0]      ALU_result,
  output logic [31:0]      MEM_read_data,
  output logic [REG_W-1:0] out_write_reg,
  output logic [1:0]       out_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [1:0]       pend_wb_q, pend_wb_d;
  logic [REG_W-1:0] pend_reg_q, pend_reg_d;
  logic             pend_load_q, pend_load_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       wb_out_q, wb_out_d, err_out_q, err_out_d;
  logic [31:0]      alu_out_q, alu_out_d, rdata_out_q, rdata_out_d;
  logic [REG_W-1:0] wreg_out_q, wreg_out_d;
  logic             is_mem, misaligned, timeout;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pend_wb_d   = pend_wb_q;
    pend_reg_d  = pend_reg_q;
    pend_load_d = pend_load_q;
    out_valid_d = 1'b0;
    wb_out_d    = wb_out_q;
    alu_out_d   = alu_out_q;
    rdata_out_d = rdata_out_q;
    wreg_out_d  = wreg_out_q;
    err_out_d   = err_out_q;
    is_mem      = in_mem_read | in_mem_write;
    misaligned  = is_mem & (|in_alu_result[1:0]);
    timeout     = cnt_q == CW'(TIMEOUT - 1);
    if (state_q == IDLE) begin
      if (in_valid && (!is_mem || misaligned)) begin
        out_valid_d = 1'b1;
        wb_out_d    = misaligned ? 2'b00 : in_wb_ctrl;
        alu_out_d   = in_alu_result;
        rdata_out_d = '0;
        wreg_out_d  = in_write_reg;
        err_out_d   = misaligned ? 2'b01 : 2'b00;
      end else if (in_valid) begin
        state_d     = ACCESS;
        cnt_d       = '0;
        mem_req_d   = 1'b1;
        mem_we_d    = in_mem_write;
        mem_addr_d  = {in_alu_result[31:2], 2'b00};
        mem_wdata_d = in_write_data;
        pend_wb_d   = in_wb_ctrl;
        pend_reg_d  = in_write_reg;
        pend_load_d = in_mem_read & ~in_mem_write;
      end
    end else if (mem_ack || timeout) begin
      // an ack on the final allowed cycle still counts as a normal completion
      state_d     = IDLE;
      mem_req_d   = 1'b0;
      out_valid_d = 1'b1;
      wb_out_d    = mem_ack ? pend_wb_q : 2'b00;
      alu_out_d   = mem_addr_q;
      rdata_out_d = (mem_ack && pend_load_q) ? mem_rdata : '0;
      wreg_out_d  = pend_reg_q;
      err_out_d   = mem_ack ? 2'b00 : 2'b10;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      pend_wb_q   <= '0;
      pend_reg_q  <= '0;
      pend_load_q <= 1'b0;
      out_valid_q <= 1'b0;
      wb_out_q    <= '0;
      alu_out_q   <= '0;
      rdata_out_q <= '0;
      wreg_out_q  <= '0;
      err_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      pend_wb_q   <= pend_wb_d;
      pend_reg_q  <= pend_reg_d;
      pend_load_q <= pend_load_d;
      out_valid_q <= out_valid_d;
      wb_out_q    <= wb_out_d;
      alu_out_q   <= alu_out_d;
      rdata_out_q <= rdata_out_d;
      wreg_out_q  <= wreg_out_d;
      err_out_q   <= err_out_d;
    end
  end
  assign stall             = state_q == ACCESS;
  assign mem_req           = mem_req_q;
  assign mem_we            = mem_we_q;
  assign mem_addr          = mem_addr_q;
  assign mem_wdata         = mem_wdata_q;
  assign out_valid         = out_valid_q;
  assign control_signal_WB = wb_out_q;
  assign ALU_result        = alu_out_q;
  assign MEM_read_data     = rdata_out_q;
  assign out_write_reg     = wreg_out_q;
  assign out_err           = err_out_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized scoreboard bench with a result-level reference model
// and a memory responder that follows a per-access ack plan.
module tb_mem_access_stage;
  localparam int TO = 16;
  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, in_mem_read = 1'b0, in_mem_write = 1'b0;
  logic [1:0] in_wb_ctrl = '0;
  logic [31:0] in_alu_result = '0, in_write_data = '0, mem_rdata = '0;
  logic [4:0] in_write_reg = '0;
  logic mem_ack = 1'b0;
  logic stall, mem_req, mem_we, out_valid;
  logic [31:0] mem_addr, mem_wdata, ALU_result, MEM_read_data;
  logic [1:0] control_signal_WB, out_err;
  logic [4:0] out_write_reg;
  typedef struct {logic [1:0] wb; logic [31:0] alu; logic [31:0] rd; logic [4:0] rg; logic [1:0] err;} exp_t;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata; int delay;} plan_t;
  exp_t eq[$];
  plan_t pq[$];
  int req_cycle = 0;
  int tests = 0, fails = 0;

  mem_access_stage #(.TIMEOUT(TO), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_wb_ctrl(in_wb_ctrl), .in_alu_result(in_alu_result),
    .in_write_data(in_write_data), .in_write_reg(in_write_reg), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .out_valid(out_valid),
    .control_signal_WB(control_signal_WB), .ALU_result(ALU_result),
    .MEM_read_data(MEM_read_data), .out_write_reg(out_write_reg), .out_err(out_err));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // Reference model: result of one instruction from its fields and the bus outcome.
  task automatic issue(input logic rd, input logic wr, input logic [1:0] wb, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] rg, input int dly, input logic [31:0] rdat);
    exp_t e;
    plan_t p;
    int g = 0;
    @(negedge clk);
    in_valid = 1'b1; in_mem_read = rd; in_mem_write = wr; in_wb_ctrl = wb;
    in_alu_result = alu; in_write_data = wd; in_write_reg = rg;
    while (stall && g < 100) begin @(negedge clk); g++; end
    if (g >= 100) chk("stall_bound", {31'd0, stall}, 32'd0);
    e.alu = alu; e.rg = rg; e.rd = 32'd0; e.wb = wb; e.err = 2'b00;
    if ((rd || wr) && alu[1:0] != 2'b00) begin
      e.wb = 2'b00; e.err = 2'b01;
    end else if (rd || wr) begin
      if (dly >= TO) begin
        e.wb = 2'b00; e.err = 2'b10;
      end else if (rd && !wr) e.rd = rdat;
      p.we = wr; p.addr = alu; p.wdata = wd; p.rdata = rdat; p.delay = dly;
      pq.push_back(p);
    end
    eq.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0; in_mem_read = $urandom; in_mem_write = $urandom; in_alu_result = $urandom;
  endtask

  task automatic drain();
    int g = 0;
    while ((eq.size() > 0 || pq.size() > 0) && g < 300) begin @(negedge clk); g++; end
    chk("drain_pending", eq.size() + pq.size(), 32'd0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst && out_valid) begin
      if (eq.size() == 0) chk("spurious_out_valid", 32'd1, 32'd0);
      else begin
        e = eq.pop_front();
        chk("wb_ctrl", {30'd0, control_signal_WB}, {30'd0, e.wb});
        chk("alu_result", ALU_result, e.alu);
        chk("read_data", MEM_read_data, e.rd);
        chk("write_reg", {27'd0, out_write_reg}, {27'd0, e.rg});
        chk("err", {30'd0, out_err}, {30'd0, e.err});
      end
    end
  end

  always @(negedge clk) begin : responder
    plan_t p;
    if (rst && mem_req) begin
      if (pq.size() == 0) begin
        chk("unplanned_req", 32'd1, 32'd0);
        mem_ack = 1'b0;
      end else begin
        p = pq[0];
        chk("mem_addr", mem_addr, p.addr);
        chk("mem_we", {31'd0, mem_we}, {31'd0, p.we});
        if (p.we) chk("mem_wdata", mem_wdata, p.wdata);
        chk("stall_in_access", {31'd0, stall}, 32'd1);
        mem_ack = (req_cycle == p.delay);
        mem_rdata = mem_ack ? p.rdata : $urandom;
        req_cycle++;
      end
    end else if (rst) begin
      if (req_cycle > 0) begin
        p = pq.pop_front();
        chk("req_cycles", req_cycle, (p.delay < TO) ? p.delay + 1 : TO);
        req_cycle = 0;
      end
      mem_ack = $urandom_range(0, 1);
      mem_rdata = $urandom;
    end
  end

  initial begin
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_alu", ALU_result, 32'd0);
    chk("rst_err", {30'd0, out_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    issue(0, 0, 2'b10, 32'h0000_1234, 32'h0, 5'd5, 0, 32'h0);
    issue(1, 0, 2'b01, 32'h0000_0040, 32'h0, 5'd7, 2, 32'hDEAD_BEEF);
    issue(0, 1, 2'b11, 32'h0000_0044, 32'hCAFE_F00D, 5'd8, 0, 32'h0);
    issue(0, 0, 2'b10, 32'h0000_0099, 32'h0, 5'd9, 0, 32'h0);
    issue(1, 0, 2'b11, 32'h0000_0042, 32'h0, 5'd10, 0, 32'h0);
    issue(1, 0, 2'b01, 32'h0000_0048, 32'h0, 5'd11, TO, 32'h1111_1111);
    issue(1, 0, 2'b01, 32'h0000_004C, 32'h0, 5'd12, TO - 1, 32'h2222_2222);
    issue(1, 1, 2'b11, 32'h0000_0050, 32'h5555_AAAA, 5'd13, 1, 32'h3333_3333);
    drain();
    issue(1, 0, 2'b01, 32'h0000_0080, 32'h0, 5'd14, TO, 32'h0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    eq.delete(); pq.delete(); req_cycle = 0; mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    issue(1, 0, 2'b01, 32'h0000_0100, 32'h0, 5'd1, 0, 32'h0BAD_F00D);
    issue(0, 0, 2'b10, 32'h0000_0777, 32'h0, 5'd2, 0, 32'h0);
    for (int i = 0; i < 200; i++) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      issue($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom), a, $urandom, 5'($urandom),
            (r < 7) ? $urandom_range(0, 3) : (r == 7) ? TO - 1 : (r == 8) ? TO : $urandom_range(0, TO),
            $urandom);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
